// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and requester ids.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;
  localparam int NUM_PORTS  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_id_e;

  // The port that loses (or did not win) gets priority on the next contention.
  function automatic port_id_e other_port(input port_id_e p);
    return (p == PORT_IF) ? PORT_LS : PORT_IF;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin grant: a lone requester always wins, i_ptr breaks ties.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  port_id_e   i_ptr,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (i_ptr == PORT_IF) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one async-read/sync-write memory between instruction fetch (port 0) and load/store
// (port 1): grant in cycle A, memory access in A+1, read data registered at the end of A+1.
//   state | meaning
//   IDLE  | no access latched; memory side driven to zero
//   BUSY  | op_* holds the access granted last cycle; memory side driven from op_*
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  port_id_e          r_rr_ptr;
  port_id_e          w_winner;
  logic [1:0]        w_req;
  logic [1:0]        w_gnt_raw;
  logic [1:0]        w_gnt;
  logic              w_accept;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_access;
  logic              w_rd_done;

  logic              r_op_we;
  logic [ADDR_W-1:0] r_op_addr;
  logic [DATA_W-1:0] r_op_wdata;
  port_id_e          r_op_port;

  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  assign w_req = {req1, req0};

  rr_arb2 u_rr_arb2 (
    .i_req (w_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt_raw)
  );

  // Grants are combinational from req, so hold them low while reset is asserted.
  assign w_gnt    = w_gnt_raw & {2{reset_n}};
  assign w_accept = |w_gnt;
  assign w_winner = w_gnt[1] ? PORT_LS : PORT_IF;

  assign w_sel_we    = (w_winner == PORT_LS) ? we1    : we0;
  assign w_sel_addr  = (w_winner == PORT_LS) ? addr1  : addr0;
  assign w_sel_wdata = (w_winner == PORT_LS) ? wdata1 : wdata0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = BUSY;
      BUSY:    w_state_nxt = w_accept ? BUSY : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_access = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_in   = '0;
    case (r_state)
      BUSY: begin
        w_access = 1'b1;
        mem_we   = r_op_we;
        mem_addr = r_op_addr;
        mem_in   = r_op_wdata;
      end
      default: begin
        w_access = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op_we    <= 1'b0;
      r_op_addr  <= '0;
      r_op_wdata <= '0;
      r_op_port  <= PORT_IF;
      r_rr_ptr   <= PORT_IF;
    end else if (w_accept) begin
      r_op_we    <= w_sel_we;
      r_op_addr  <= w_sel_addr;
      r_op_wdata <= w_sel_wdata;
      r_op_port  <= w_winner;
      r_rr_ptr   <= other_port(w_winner);
    end
  end

  assign w_rd_done = w_access & ~r_op_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_rd_done && (r_op_port == PORT_IF);
      r_rvalid1 <= w_rd_done && (r_op_port == PORT_LS);
      if (w_rd_done && (r_op_port == PORT_IF)) r_rdata0 <= mem_out;
      if (w_rd_done && (r_op_port == PORT_LS)) r_rdata1 <= mem_out;
    end
  end

  assign gnt0    = w_gnt[0];
  assign gnt1    = w_gnt[1];
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a word-array memory model, directed scenarios and a random run.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_in, mem_out;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] ram [64];
  logic          pl_en   = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  typedef struct { int due; logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } acc_t;
  typedef struct { int due; logic [DW-1:0] data; } rd_t;

  acc_t          q_acc[$];
  rd_t           q_rd0[$];
  rd_t           q_rd1[$];
  logic [DW-1:0] m_ram [64];
  int            m_prio = 0;
  logic [DW-1:0] last0 = '0, last1 = '0;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_we) ram[mem_addr] <= mem_in;
  end
  assign mem_out = ram[mem_addr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    pl_en = 1'b1; pl_addr = a; pl_data = d; m_ram[a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // One cycle of stimulus; predicts the winner, checks the grants, queues expected effects.
  task automatic step(input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      output int win);
    acc_t e;
    rd_t  r;
    @(posedge clk); #1;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    if (r0 && r1) win = m_prio;
    else if (r0)  win = 0;
    else if (r1)  win = 1;
    else          win = -1;
    @(negedge clk);
    check("gnt0", gnt0, win == 0);
    check("gnt1", gnt1, win == 1);
    if (win >= 0) begin
      e.due  = cyc + 1;
      e.we   = (win == 1) ? w1 : w0;
      e.addr = (win == 1) ? a1 : a0;
      e.data = (win == 1) ? d1 : d0;
      m_prio = (win == 0) ? 1 : 0;
      q_acc.push_back(e);
      if (e.we) begin
        m_ram[e.addr] = e.data;
      end else begin
        r.due  = cyc + 2;
        r.data = m_ram[e.addr];
        if (win == 0) q_rd0.push_back(r);
        else          q_rd1.push_back(r);
      end
    end
  endtask

  task automatic idle(input int n);
    int w;
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, w);
  endtask

  // Assert reset a little after an edge, check outputs clear at once, then release.
  task automatic reset_pulse();
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_rvalid", {rvalid0, rvalid1}, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_side", {mem_addr, mem_in}, 0);
    req0 = 1'b0; req1 = 1'b0;
    q_acc.delete(); q_rd0.delete(); q_rd1.delete();
    m_prio = 0; last0 = '0; last1 = '0;
    @(posedge clk); #3;
    reset_n = 1'b1;
  endtask

  initial begin : monitor
    acc_t a;
    rd_t  r;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        check("gnt_exclusive", gnt0 & gnt1, 0);
        if (q_acc.size() > 0 && q_acc[0].due == cyc) begin
          a = q_acc.pop_front();
          check("mem_we", mem_we, a.we);
          check("mem_addr", mem_addr, a.addr);
          if (a.we) check("mem_in", mem_in, a.data);
        end else begin
          check("mem_idle", {mem_we, mem_addr, mem_in}, 0);
        end
        if (q_rd0.size() > 0 && q_rd0[0].due == cyc) begin
          r = q_rd0.pop_front();
          check("rvalid0", rvalid0, 1);
          check("rdata0", rdata0, r.data);
          last0 = r.data;
        end else begin
          check("rvalid0_idle", rvalid0, 0);
          check("rdata0_hold", rdata0, last0);
        end
        if (q_rd1.size() > 0 && q_rd1[0].due == cyc) begin
          r = q_rd1.pop_front();
          check("rvalid1", rvalid1, 1);
          check("rdata1", rdata1, r.data);
          last1 = r.data;
        end else begin
          check("rvalid1_idle", rvalid1, 0);
          check("rdata1_hold", rdata1, last1);
        end
      end
    end
  end

  initial begin : stimulus
    int            w;
    logic [DW-1:0] old;
    logic          p0v, p0we, p1v, p1we;
    logic [AW-1:0] p0a, p1a;
    logic [DW-1:0] p0d, p1d;

    #2 reset_n = 1'b0;
    #1;
    check("init_gnt", {gnt0, gnt1}, 0);
    check("init_rvalid", {rvalid0, rvalid1}, 0);
    check("init_rdata", {rdata0, rdata1}, 0);
    check("init_mem", {mem_we, mem_addr, mem_in}, 0);
    for (int i = 0; i < 64; i++) preload(6'(i), $urandom);
    @(posedge clk); #3;
    reset_n = 1'b1;
    idle(2);

    // single read on port 0
    preload(6'd5, 32'hDEAD_BEEF);
    step(1, 0, 6'd5, '0, 0, 0, '0, '0, w);
    idle(3);

    // write then read-after-write on port 1
    step(0, 0, '0, '0, 1, 1, 6'd9, 32'h0000_00A5, w);
    step(0, 0, '0, '0, 1, 0, 6'd9, '0, w);
    idle(3);

    // contention straight out of reset
    reset_pulse();
    for (int i = 0; i < 6; i++) step(1, 0, 6'(i), '0, 1, 0, 6'(i + 20), '0, w);
    idle(3);

    // reset in the middle of a contended burst; port 0 must win first again afterwards
    for (int i = 0; i < 3; i++) step(1, 0, 6'(i + 30), '0, 1, 0, 6'(i + 40), '0, w);
    reset_pulse();
    step(1, 0, 6'd1, '0, 1, 0, 6'd2, '0, w);
    idle(3);

    // write granted, then reset before it commits: location keeps its old value
    old = m_ram[12];
    step(0, 0, '0, '0, 1, 1, 6'd12, ~old, w);
    reset_pulse();
    m_ram[12] = old;
    check("dropped_write", ram[12], old);
    step(1, 0, 6'd12, '0, 0, 0, '0, '0, w);
    idle(3);

    // back-to-back reads across the full address range, including the wrap
    for (int i = 0; i < 66; i++) step(1, 0, 6'(i), '0, 0, 0, '0, '0, w);
    idle(3);

    // random traffic, requests held until granted
    p0v = 1'b0; p1v = 1'b0;
    p0we = 1'b0; p1we = 1'b0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
    for (int c = 0; c < 400; c++) begin
      if (!p0v && $urandom_range(0, 99) < 70) begin
        p0v = 1'b1; p0we = ($urandom_range(0, 2) == 0);
        p0a = 6'($urandom_range(0, 7)); p0d = $urandom;
      end
      if (!p1v && $urandom_range(0, 99) < 70) begin
        p1v = 1'b1; p1we = ($urandom_range(0, 2) == 0);
        p1a = 6'($urandom_range(0, 7)); p1d = $urandom;
      end
      step(p0v, p0we, p0a, p0d, p1v, p1we, p1a, p1d, w);
      if (w == 0) p0v = 1'b0;
      else if (w == 1) p1v = 1'b0;
    end
    idle(4);

    check("drain", q_acc.size() + q_rd0.size() + q_rd1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
